// File: rtl/sd_tagdemux_pkg.sv
// sd_tagdemux_pkg: shared types, tag extraction and p_data slicing for sd_tagdemux.
package sd_tagdemux_pkg;

    localparam int STAT_W = 16;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    function automatic logic [31:0] tag_of(input logic [63:0] data, input int lsb, input int sz);
        return 32'((data >> lsb) & ((64'd1 << sz) - 64'd1));
    endfunction

endpackage

`define SD_TAGDEMUX_SLICE(i, w) (i)*(w) +: (w)

// File: rtl/sd_tagdemux_slot.sv
// sd_tagdemux_slot: one-entry output holding register with srdy/drdy handshake.
module sd_tagdemux_slot
    import sd_tagdemux_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] data,
    input  logic             drdy,
    output logic             srdy,
    output logic [width-1:0] q
);

    slot_state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            q     <= '0;
        end else begin
            state <= state_next;
            if (load) q <= data;
        end
    end

    // A load wins over a drain, so a FULL slot stays FULL and streams one word per cycle.
    always_comb begin
        state_next = state;
        if (load)
            state_next = SLOT_FULL;
        else if (state == SLOT_FULL && drdy)
            state_next = SLOT_EMPTY;
    end

    assign srdy = (state == SLOT_FULL);

endmodule

// File: rtl/sd_tagdemux.sv
// sd_tagdemux: routes a merged srdy/drdy stream to per-tag one-entry output slots.
// Define SD_TAGDEMUX_STATS_EN to add per-output load counters and a drop counter.
module sd_tagdemux
    import sd_tagdemux_pkg::*;
#(
    parameter int width   = 8,
    parameter int outputs = 4,
    parameter int tag_sz  = 2,
    parameter int tag_lsb = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c_srdy,
    output logic                      c_drdy,
    input  logic [width-1:0]          c_data,
    output logic [outputs-1:0]        p_srdy,
    input  logic [outputs-1:0]        p_drdy,
    output logic [outputs*width-1:0]  p_data
`ifdef SD_TAGDEMUX_STATS_EN
    ,
    output logic [outputs*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]         stat_drop
`endif
);

    localparam int slots = 2 ** tag_sz;

    logic [tag_sz-1:0]  tag;
    logic               in_range;
    logic               xfer;
    logic [slots-1:0]   full_pad;
    logic [slots-1:0]   drdy_pad;
    logic [outputs-1:0] load;

    assign tag      = tag_sz'(tag_of(64'(c_data), tag_lsb, tag_sz));
    assign in_range = int'(tag) < outputs;

    // Pad to the full tag space so out-of-range tags index safely.
    always_comb begin
        full_pad = '0;
        drdy_pad = '0;
        full_pad[outputs-1:0] = p_srdy;
        drdy_pad[outputs-1:0] = p_drdy;
    end

    assign c_drdy = ~in_range | ~full_pad[tag] | drdy_pad[tag];
    assign xfer   = c_srdy & c_drdy;

    for (genvar i = 0; i < outputs; i++) begin : g_slot
        assign load[i] = xfer & in_range & (int'(tag) == i);
        sd_tagdemux_slot #(.width(width)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .data  (c_data),
            .drdy  (p_drdy[i]),
            .srdy  (p_srdy[i]),
            .q     (p_data[`SD_TAGDEMUX_SLICE(i, width)])
        );
    end

`ifdef SD_TAGDEMUX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cnt  <= '0;
            stat_drop <= '0;
        end else begin
            for (int i = 0; i < outputs; i++)
                if (load[i])
                    stat_cnt[i*STAT_W +: STAT_W] <= stat_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
            if (xfer & ~in_range)
                stat_drop <= stat_drop + STAT_W'(1);
        end
    end
`else
`endif

endmodule
